// File: rtl/sift_pkg.sv
// Shared constants and scheduler state type for the SIFT descriptor pipeline.
// Orientation bin count, direction width and default image geometry live here.
package sift_pkg;

    localparam int DIR_BINS    = 36;
    localparam int DIR_W       = 6;
    localparam int SIFT_BORDER = 10;
    localparam int SIFT_IMG_H  = 1024;
    localparam int SIFT_IMG_W  = 256;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_CHECK,
        S_ORI,
        S_DESC,
        S_OUT,
        S_FIN
    } sched_state_t;

endpackage

// File: rtl/sift_border_chk.sv
// Combinational border test on a {row,col} keypoint coordinate.
// Accepts iff BORDER < row < IMG_H-BORDER and BORDER < col < IMG_W-BORDER.
module sift_border_chk
    import sift_pkg::*;
#(
    parameter int ROW_BITS = 10,
    parameter int COL_BITS = 8,
    parameter int IMG_H    = SIFT_IMG_H,
    parameter int IMG_W    = SIFT_IMG_W,
    parameter int BORDER   = SIFT_BORDER
) (
    input  logic [ROW_BITS+COL_BITS-1:0] coord,
    output logic                         ok
);

    // Limits are sized to the field widths so the compares stay unsigned.
    localparam logic [ROW_BITS-1:0] ROW_LO = ROW_BITS'(BORDER);
    localparam logic [ROW_BITS-1:0] ROW_HI = ROW_BITS'(IMG_H - BORDER);
    localparam logic [COL_BITS-1:0] COL_LO = COL_BITS'(BORDER);
    localparam logic [COL_BITS-1:0] COL_HI = COL_BITS'(IMG_W - BORDER);

    logic [ROW_BITS-1:0] row;
    logic [COL_BITS-1:0] col;

    always_comb begin
        row = coord[ROW_BITS+COL_BITS-1:COL_BITS];
        col = coord[COL_BITS-1:0];
        ok  = (row > ROW_LO) && (row < ROW_HI) && (col > COL_LO) && (col < COL_HI);
    end

endmodule

// File: rtl/sift_desc_sched.sv
// Keypoint scheduler: fetch, border check, orientation, descriptor, buffered output.
// Optional SIFT_DESC_SCHED_STATS_EN adds saturating accept/reject counters.
module sift_desc_sched
    import sift_pkg::*;
#(
    parameter int ROW_BITS = 10,
    parameter int COL_BITS = 8,
    parameter int IMG_H    = SIFT_IMG_H,
    parameter int IMG_W    = SIFT_IMG_W,
    parameter int BORDER   = SIFT_BORDER,
    parameter int KP_AW    = 10,
    parameter int DESC_W   = 1024,
    parameter int RAM_LAT  = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [KP_AW:0]               kp_num,
    output logic [KP_AW-1:0]             kp_addr,
    input  logic [ROW_BITS+COL_BITS-1:0] kp_data,
    output logic [ROW_BITS+COL_BITS-1:0] kp_coord,
    output logic                         ori_start,
    input  logic                         ori_done,
    input  logic [DIR_W-1:0]             ori_dir,
    input  logic [ROW_BITS+COL_BITS-1:0] ori_addr,
    output logic                         desc_start,
    input  logic                         desc_done,
    input  logic [ROW_BITS+COL_BITS-1:0] desc_addr,
    input  logic [DESC_W-1:0]            desc_in,
    output logic [DIR_W-1:0]             main_dir,
    output logic [ROW_BITS+COL_BITS-1:0] gd_addr,
    output logic [DESC_W-1:0]            desc_out,
    output logic [ROW_BITS+COL_BITS-1:0] desc_kp,
    output logic                         desc_valid,
    input  logic                         desc_ready,
    output logic                         busy,
    output logic                         done
`ifdef SIFT_DESC_SCHED_STATS_EN
    ,
    output logic [KP_AW:0]               kp_acc_cnt,
    output logic [KP_AW:0]               kp_rej_cnt
`endif
);

    localparam int CW    = ROW_BITS + COL_BITS;
    localparam int LAT_W = (RAM_LAT < 2) ? 1 : $clog2(RAM_LAT + 1);
    localparam logic [KP_AW:0] ONE = (KP_AW+1)'(1);

    sched_state_t        state_q, state_d;
    logic [KP_AW:0]      idx_q, idx_d, num_q, num_d;
    logic [LAT_W-1:0]    lat_q, lat_d;
    logic [CW-1:0]       coord_q, coord_d, dkp_q, dkp_d;
    logic [DIR_W-1:0]    dir_q, dir_d;
    logic [DESC_W-1:0]   dout_q, dout_d;
    logic                dvalid_q, dvalid_d;
    logic                ori_start_q, ori_start_d, desc_start_q, desc_start_d;
    logic                done_q, done_d;
    logic                kp_ok, advance;

    sift_border_chk #(
        .ROW_BITS (ROW_BITS),
        .COL_BITS (COL_BITS),
        .IMG_H    (IMG_H),
        .IMG_W    (IMG_W),
        .BORDER   (BORDER)
    ) u_border_chk (
        .coord (coord_q),
        .ok    (kp_ok)
    );

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        num_d        = num_q;
        lat_d        = lat_q;
        coord_d      = coord_q;
        dir_d        = dir_q;
        dout_d       = dout_q;
        dkp_d        = dkp_q;
        dvalid_d     = dvalid_q;
        ori_start_d  = 1'b0;
        desc_start_d = 1'b0;
        done_d       = 1'b0;
        gd_addr      = '0;
        advance      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (kp_num == '0) begin
                        state_d = S_FIN;
                    end else begin
                        num_d   = kp_num;
                        idx_d   = '0;
                        state_d = S_FETCH;
                    end
                end
            end
            // Address is presented on entry; data is captured RAM_LAT cycles later.
            S_FETCH: begin
                if (lat_q == LAT_W'(RAM_LAT)) begin
                    lat_d   = '0;
                    coord_d = kp_data;
                    state_d = S_CHECK;
                end else begin
                    lat_d = lat_q + LAT_W'(1);
                end
            end
            S_CHECK: begin
                if (kp_ok) begin
                    ori_start_d = 1'b1;
                    state_d     = S_ORI;
                end else begin
                    advance = 1'b1;
                end
            end
            S_ORI: begin
                gd_addr = ori_addr;
                if (ori_done) begin
                    dir_d        = ori_dir;
                    desc_start_d = 1'b1;
                    state_d      = S_DESC;
                end
            end
            S_DESC: begin
                gd_addr = desc_addr;
                if (desc_done) begin
                    dout_d   = desc_in;
                    dkp_d    = coord_q;
                    dvalid_d = 1'b1;
                    state_d  = S_OUT;
                end
            end
            S_OUT: begin
                if (desc_ready) begin
                    dvalid_d = 1'b0;
                    advance  = 1'b1;
                end
            end
            S_FIN: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (advance) begin
            if (idx_q == num_q - ONE) begin
                state_d = S_FIN;
            end else begin
                idx_d   = idx_q + ONE;
                state_d = S_FETCH;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            idx_q        <= '0;
            num_q        <= '0;
            lat_q        <= '0;
            coord_q      <= '0;
            dir_q        <= '0;
            dout_q       <= '0;
            dkp_q        <= '0;
            dvalid_q     <= 1'b0;
            ori_start_q  <= 1'b0;
            desc_start_q <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            num_q        <= num_d;
            lat_q        <= lat_d;
            coord_q      <= coord_d;
            dir_q        <= dir_d;
            dout_q       <= dout_d;
            dkp_q        <= dkp_d;
            dvalid_q     <= dvalid_d;
            ori_start_q  <= ori_start_d;
            desc_start_q <= desc_start_d;
            done_q       <= done_d;
        end
    end

    always_comb begin
        kp_addr    = idx_q[KP_AW-1:0];
        kp_coord   = coord_q;
        ori_start  = ori_start_q;
        desc_start = desc_start_q;
        main_dir   = dir_q;
        desc_out   = dout_q;
        desc_kp    = dkp_q;
        desc_valid = dvalid_q;
        busy       = (state_q != S_IDLE);
        done       = done_q;
    end

`ifdef SIFT_DESC_SCHED_STATS_EN
    logic [KP_AW:0] acc_q, acc_d, rej_q, rej_d;

    always_comb begin
        acc_d = acc_q;
        rej_d = rej_q;
        if (state_q == S_IDLE && start) begin
            acc_d = '0;
            rej_d = '0;
        end else if (state_q == S_CHECK) begin
            if (kp_ok) begin
                if (acc_q != '1) acc_d = acc_q + ONE;
            end else begin
                if (rej_q != '1) rej_d = rej_q + ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q <= '0;
            rej_q <= '0;
        end else begin
            acc_q <= acc_d;
            rej_q <= rej_d;
        end
    end

    always_comb begin
        kp_acc_cnt = acc_q;
        kp_rej_cnt = rej_q;
    end
`endif

endmodule

// File: tb/tb_sift_desc_sched.sv
// Directed self-checking bench for sift_desc_sched (DESC_W reduced to 64).
// Build with SIFT_DESC_SCHED_STATS_EN to also check the accept/reject counters.
module tb_sift_desc_sched;

    localparam int CW = 18;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [10:0]   kp_num = '0;
    logic [9:0]    kp_addr;
    logic [CW-1:0] kp_data = '0;
    logic [CW-1:0] kp_coord;
    logic          ori_start, desc_start;
    logic          ori_done, desc_done;
    logic [5:0]    ori_dir = 6'd17;
    logic [CW-1:0] ori_addr = 18'h1_1111;
    logic [CW-1:0] desc_addr = 18'h2_2222;
    logic [63:0]   desc_in = '0;
    logic [5:0]    main_dir;
    logic [CW-1:0] gd_addr;
    logic [63:0]   desc_out;
    logic [CW-1:0] desc_kp;
    logic          desc_valid;
    logic          desc_ready = 1'b1;
    logic          busy, done;
`ifdef SIFT_DESC_SCHED_STATS_EN
    logic [10:0]   kp_acc_cnt, kp_rej_cnt;
`endif

    logic          eng_auto = 1'b1;
    logic          eng_ori_done = 1'b0, eng_desc_done = 1'b0;
    logic          man_ori_done = 1'b0, man_desc_done = 1'b0;
    assign ori_done  = eng_ori_done | man_ori_done;
    assign desc_done = eng_desc_done | man_desc_done;

    int checks = 0;
    int errors = 0;

    sift_desc_sched #(.DESC_W(64)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .kp_num     (kp_num),
        .kp_addr    (kp_addr),
        .kp_data    (kp_data),
        .kp_coord   (kp_coord),
        .ori_start  (ori_start),
        .ori_done   (ori_done),
        .ori_dir    (ori_dir),
        .ori_addr   (ori_addr),
        .desc_start (desc_start),
        .desc_done  (desc_done),
        .desc_addr  (desc_addr),
        .desc_in    (desc_in),
        .main_dir   (main_dir),
        .gd_addr    (gd_addr),
        .desc_out   (desc_out),
        .desc_kp    (desc_kp),
        .desc_valid (desc_valid),
        .desc_ready (desc_ready),
        .busy       (busy),
        .done       (done)
`ifdef SIFT_DESC_SCHED_STATS_EN
        ,
        .kp_acc_cnt (kp_acc_cnt),
        .kp_rej_cnt (kp_rej_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Keypoint RAM with one cycle of read latency, updated away from the active edge.
    logic [CW-1:0] mem [0:15];
    logic [9:0]    addr_d = '0;
    always @(negedge clk) begin
        kp_data = mem[addr_d[3:0]];
        addr_d  = kp_addr;
    end

    // Engines answer five cycles after their start pulse.
    int o_cnt = 0, d_cnt = 0;
    always @(negedge clk) begin
        eng_ori_done  = 1'b0;
        eng_desc_done = 1'b0;
        if (!eng_auto) begin
            o_cnt = 0;
            d_cnt = 0;
        end else begin
            if (ori_start) o_cnt = 5;
            else if (o_cnt != 0) begin
                o_cnt--;
                if (o_cnt == 0) eng_ori_done = 1'b1;
            end
            if (desc_start) d_cnt = 5;
            else if (d_cnt != 0) begin
                d_cnt--;
                if (d_cnt == 0) eng_desc_done = 1'b1;
            end
        end
    end

    int n_ori = 0, n_desc = 0, n_valid = 0, n_hs = 0, n_done = 0;
    logic [CW-1:0] last_kp = '0;
    logic [63:0]   last_out = '0;
    always @(negedge clk) begin
        if (ori_start) n_ori++;
        if (desc_start) n_desc++;
        if (desc_valid) n_valid++;
        if (desc_valid && desc_ready) begin
            n_hs++;
            last_kp  = desc_kp;
            last_out = desc_out;
        end
        if (done) n_done++;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [CW-1:0] kp(input int r, input int c);
        return {10'(r), 8'(c)};
    endfunction

    task automatic pulse_start(input logic [10:0] n);
        @(negedge clk);
        kp_num = n;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
    endtask

    // sel: 0 done, 1 ori_start, 2 desc_valid; returns at the negedge where it is seen.
    task automatic wait_high(input string tag, input int sel, input int limit);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < limit && !seen; i++) begin
            @(negedge clk);
            case (sel)
                0: seen = done;
                1: seen = ori_start;
                default: seen = desc_valid;
            endcase
        end
        if (!seen) check({tag, "_timeout"}, 64'd0, 64'd1);
    endtask

    task automatic check_zero(input string pre);
        check({pre, "_busy"}, 64'(busy), 64'd0);
        check({pre, "_done"}, 64'(done), 64'd0);
        check({pre, "_kp_addr"}, 64'(kp_addr), 64'd0);
        check({pre, "_kp_coord"}, 64'(kp_coord), 64'd0);
        check({pre, "_starts"}, 64'({ori_start, desc_start}), 64'd0);
        check({pre, "_main_dir"}, 64'(main_dir), 64'd0);
        check({pre, "_gd_addr"}, 64'(gd_addr), 64'd0);
        check({pre, "_desc_out"}, desc_out, 64'd0);
        check({pre, "_desc_kp"}, 64'(desc_kp), 64'd0);
        check({pre, "_desc_valid"}, 64'(desc_valid), 64'd0);
    endtask

    int b_ori, b_desc, b_valid, b_hs, b_done;
    task automatic snap();
        b_ori = n_ori; b_desc = n_desc; b_valid = n_valid; b_hs = n_hs; b_done = n_done;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = '0;
        repeat (3) @(negedge clk);
        check_zero("rst");
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // 1: three central keypoints, ready held high
        for (int i = 0; i < 3; i++) mem[i] = kp(100, 100);
        desc_in = 64'hCAFE_F00D_1234_5678;
        snap();
        pulse_start(11'd3);
        wait_high("t1_done", 0, 300);
        check("t1_busy_at_done", 64'(busy), 64'd0);
        @(negedge clk);
        check("t1_done_width", 64'(done), 64'd0);
        check("t1_ori_starts", 64'(n_ori - b_ori), 64'd3);
        check("t1_desc_starts", 64'(n_desc - b_desc), 64'd3);
        check("t1_valid_cycles", 64'(n_valid - b_valid), 64'd3);
        check("t1_handshakes", 64'(n_hs - b_hs), 64'd3);
        check("t1_done_pulses", 64'(n_done - b_done), 64'd1);
        check("t1_desc_kp", 64'(last_kp), 64'(kp(100, 100)));
        check("t1_desc_out", last_out, 64'hCAFE_F00D_1234_5678);
        check("t1_main_dir", 64'(main_dir), 64'd17);

        // 2: border rejects on row and on col == IMG_W-BORDER
        mem[0] = kp(5, 100);
        mem[1] = kp(100, 246);
        mem[2] = kp(100, 245);
        desc_in = 64'h0000_0000_0000_BEEF;
        snap();
        pulse_start(11'd3);
        wait_high("t2_done", 0, 300);
        @(negedge clk);
        check("t2_ori_starts", 64'(n_ori - b_ori), 64'd1);
        check("t2_handshakes", 64'(n_hs - b_hs), 64'd1);
        check("t2_desc_kp", 64'(last_kp), 64'(kp(100, 245)));
        check("t2_kp_addr_last", 64'(kp_addr), 64'd2);
`ifdef SIFT_DESC_SCHED_STATS_EN
        check("t6_acc_cnt", 64'(kp_acc_cnt), 64'd1);
        check("t6_rej_cnt", 64'(kp_rej_cnt), 64'd2);
`endif

        // 3: consumer stalls for 20 cycles in OUT
        mem[0] = kp(200, 50);
        mem[1] = kp(300, 60);
        desc_in = 64'h0123_4567_89AB_CDEF;
        desc_ready = 1'b0;
        snap();
        pulse_start(11'd2);
        wait_high("t3_valid", 2, 100);
        begin
            logic [63:0]   s_out;
            logic [CW-1:0] s_kp;
            logic          unstable;
            s_out = desc_out;
            s_kp  = desc_kp;
            unstable = 1'b0;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (desc_out !== s_out || desc_kp !== s_kp || !desc_valid || kp_addr !== 10'd0)
                    unstable = 1'b1;
            end
            check("t3_stall_stable", 64'(unstable), 64'd0);
            check("t3_stall_kp", 64'(s_kp), 64'(kp(200, 50)));
        end
        desc_ready = 1'b1;
        @(negedge clk);
        check("t3_valid_drop", 64'(desc_valid), 64'd0);
        check("t3_addr_adv", 64'(kp_addr), 64'd1);
        wait_high("t3_done", 0, 200);
        @(negedge clk);
        check("t3_handshakes", 64'(n_hs - b_hs), 64'd2);
        check("t3_last_kp", 64'(last_kp), 64'(kp(300, 60)));

        // 4: empty list, then start while busy
        snap();
        pulse_start(11'd0);
        check("t4_empty_done_early", 64'(done), 64'd0);
        @(negedge clk);
        check("t4_empty_done", 64'(done), 64'd1);
        check("t4_empty_addr", 64'(kp_addr), 64'd1);
        @(negedge clk);
        check("t4_empty_no_ori", 64'(n_ori - b_ori), 64'd0);
        mem[0] = kp(100, 100);
        snap();
        pulse_start(11'd1);
        repeat (2) @(negedge clk);
        check("t4_busy", 64'(busy), 64'd1);
        pulse_start(11'd3);
        wait_high("t4_done", 0, 200);
        repeat (3) @(negedge clk);
        check("t4_busy_start_hs", 64'(n_hs - b_hs), 64'd1);
        check("t4_busy_start_done", 64'(n_done - b_done), 64'd1);

        // 5: stray done pulses, gd_addr mux, reset mid-DESC
        eng_auto = 1'b0;
        snap();
        pulse_start(11'd1);
        wait_high("t5_ori_start", 1, 50);
        check("t5_gd_ori", 64'(gd_addr), 64'h1_1111);
        man_desc_done = 1'b1;
        @(negedge clk);
        man_desc_done = 1'b0;
        check("t5_stray_desc_done", 64'({desc_start, desc_valid}), 64'd0);
        check("t5_gd_still_ori", 64'(gd_addr), 64'h1_1111);
        ori_dir = 6'd33;
        man_ori_done = 1'b1;
        @(negedge clk);
        man_ori_done = 1'b0;
        ori_dir = 6'd5;
        check("t5_desc_start", 64'(desc_start), 64'd1);
        check("t5_gd_desc", 64'(gd_addr), 64'h2_2222);
        check("t5_main_dir", 64'(main_dir), 64'd33);
        man_ori_done = 1'b1;
        @(negedge clk);
        man_ori_done = 1'b0;
        check("t5_stray_ori_dir", 64'(main_dir), 64'd33);
        check("t5_gd_still_desc", 64'(gd_addr), 64'h2_2222);
        check("t5_no_valid", 64'(desc_valid), 64'd0);
        rst = 1'b0;
        #1;
        check_zero("t5_rst");
        @(negedge clk);
        rst = 1'b1;
        repeat (10) @(negedge clk);
        check("t5_no_done", 64'(n_done - b_done), 64'd0);
        check("t5_idle", 64'(busy), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
